// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of a clocked ALU: owns a 32 x N register file,
// issues one ALU operation per accepted instruction and writes alu_z back to rd.
module alu_issue #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [31:0]  instr,
   output logic [N-1:0] alu_x,
   output logic [N-1:0] alu_y,
   output logic [3:0]   alu_mode,
   input  logic [N-1:0] alu_z,
   output logic         done,
   output logic         err,
   output logic [N-1:0] result,
   input  logic [4:0]   dbg_addr,
   output logic [N-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [N-1:0] regs_q [32];
   logic [N-1:0] regs_d [32];
   logic [N-1:0] alu_x_q, alu_x_d;
   logic [N-1:0] alu_y_q, alu_y_d;
   logic [3:0]   alu_mode_q, alu_mode_d;
   logic [4:0]   rd_q, rd_d;
   logic         done_q, done_d;
   logic         err_q, err_d;
   logic [N-1:0] result_q, result_d;

   logic [3:0]   instr_op;
   logic [4:0]   instr_rd;
   logic [4:0]   instr_rs;
   logic [4:0]   instr_rt;
   logic         instr_imm_sel;
   logic [11:0]  instr_imm;
   logic [N-1:0] rs_val;
   logic [N-1:0] rt_val;
   logic [N-1:0] imm_ext;

   // Mode codes 0000 and 1100 are not ALU operations; they retire at once with err.
   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b1100: op_legal = 1'b0;
         default:          op_legal = 1'b1;
      endcase
   endfunction

   assign instr_op      = instr[31:28];
   assign instr_rd      = instr[27:23];
   assign instr_rs      = instr[22:18];
   assign instr_rt      = instr[17:13];
   assign instr_imm_sel = instr[12];
   assign instr_imm     = instr[11:0];

   // Operand read and immediate zero-extension.
   always_comb begin
      rs_val         = (instr_rs == 5'd0) ? {N{1'b0}} : regs_q[instr_rs];
      rt_val         = (instr_rt == 5'd0) ? {N{1'b0}} : regs_q[instr_rt];
      imm_ext        = {N{1'b0}};
      imm_ext[11:0]  = instr_imm;
   end

   // Next-state and datapath updates; alu_mode defaults to no-op so it is non-zero for one cycle only.
   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      alu_x_d    = alu_x_q;
      alu_y_d    = alu_y_q;
      alu_mode_d = 4'b0000;
      rd_d       = rd_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      result_d   = result_q;
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               if (op_legal(instr_op)) begin
                  alu_x_d    = rs_val;
                  alu_y_d    = instr_imm_sel ? imm_ext : rt_val;
                  alu_mode_d = instr_op;
                  rd_d       = instr_rd;
                  state_d    = ISSUE;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d = WB;
         end
         WB: begin
            if (rd_q != 5'd0) begin
               regs_d[rd_q] = alu_z;
            end else begin
               regs_d[0] = {N{1'b0}};
            end
            result_d = alu_z;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= {N{1'b0}};
         end
         alu_x_q    <= {N{1'b0}};
         alu_y_q    <= {N{1'b0}};
         alu_mode_q <= 4'b0000;
         rd_q       <= 5'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= {N{1'b0}};
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         alu_x_q    <= alu_x_d;
         alu_y_q    <= alu_y_d;
         alu_mode_q <= alu_mode_d;
         rd_q       <= rd_d;
         done_q     <= done_d;
         err_q      <= err_d;
         result_q   <= result_d;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign alu_x       = alu_x_q;
   assign alu_y       = alu_y_q;
   assign alu_mode    = alu_mode_q;
   assign done        = done_q;
   assign err         = err_q;
   assign result      = result_q;
   assign dbg_data    = (dbg_addr == 5'd0) ? {N{1'b0}} : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small clocked ALU model driving alu_z.
module tb_alu_issue;
   localparam int N = 32;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_MFHI = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [31:0]  instr = 32'd0;
   logic [N-1:0] alu_x, alu_y, result, dbg_data;
   logic [N-1:0] alu_z = {N{1'b0}};
   logic [N-1:0] hi = {N{1'b0}};
   logic [3:0]   alu_mode;
   logic         done, err;
   logic [4:0]   dbg_addr = 5'd0;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int mode_cnt = 0;

   alu_issue #(.N(N)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_x(alu_x), .alu_y(alu_y), .alu_mode(alu_mode), .alu_z(alu_z),
      .done(done), .err(err), .result(result), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Clocked ALU model: z and hi registered from x/y/mode; mode 0 holds.
   logic [2*N-1:0] prod;
   assign prod = {{N{1'b0}}, alu_x} * {{N{1'b0}}, alu_y};

   always @(posedge clk) begin
      case (alu_mode)
         OP_ADD:  alu_z <= alu_x + alu_y;
         OP_SUB:  alu_z <= alu_x - alu_y;
         OP_MUL:  begin alu_z <= prod[N-1:0]; hi <= prod[2*N-1:N]; end
         OP_DIV:  begin
            if (alu_y != {N{1'b0}}) begin alu_z <= alu_x / alu_y; hi <= alu_x % alu_y; end
            else alu_z <= {N{1'b1}};
         end
         OP_MFHI: alu_z <= hi;
         OP_SLT:  alu_z <= ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
         default: alu_z <= alu_z;
      endcase
   end

   // Count retirements and cycles in which the ALU sees a non-zero mode.
   always @(posedge clk) begin
      done_cnt <= done_cnt + (done ? 1 : 0);
      mode_cnt <= mode_cnt + ((alu_mode != 4'd0) ? 1 : 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic rd_reg(input logic [4:0] a, output logic [N-1:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic isel, input logic [11:0] imm);
      return {op, rd, rs, rt, isel, imm};
   endfunction

   typedef struct {
      string        name;
      logic [31:0]  ins;
      int           exp_lat;
      logic         exp_err;
      logic [N-1:0] exp_res;
      logic [4:0]   chk_reg;
      logic [N-1:0] exp_reg;
      int           exp_modes;
   } vec_t;

   vec_t vecs [11];

   // Issue one instruction from IDLE and observe it for six cycles.
   task automatic run_vec(input vec_t v);
      int lat, d0, m0;
      logic e;
      logic [N-1:0] res, rv;
      lat = 0; e = 1'b0; res = {N{1'b0}};
      @(negedge clk);
      chk({v.name, "_ready"}, instr_ready, 1'b1);
      d0 = done_cnt; m0 = mode_cnt;
      instr = v.ins; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (done && lat == 0) begin lat = k; e = err; res = result; end
      end
      chk({v.name, "_latency"}, lat, v.exp_lat);
      chk({v.name, "_err"}, e, v.exp_err);
      chk({v.name, "_result"}, res, v.exp_res);
      chk({v.name, "_done_pulses"}, done_cnt - d0, 1);
      chk({v.name, "_mode_cycles"}, mode_cnt - m0, v.exp_modes);
      rd_reg(v.chk_reg, rv);
      chk({v.name, "_reg"}, rv, v.exp_reg);
   endtask

   initial begin
      int nz, gap, d0, m0;
      logic [N-1:0] rv;

      vecs[0]  = '{"mul_r3",     mk(OP_MUL, 5'd3, 5'd2, 5'd2, 1'b0, 12'h000), 3, 1'b0, 32'd144, 5'd3, 32'd144, 1};
      vecs[1]  = '{"illegal_1100", mk(4'b1100, 5'd5, 5'd1, 5'd2, 1'b1, 12'h007), 1, 1'b1, 32'd144, 5'd5, 32'd0, 0};
      vecs[2]  = '{"mfhi_r4",    mk(OP_MFHI, 5'd4, 5'd0, 5'd0, 1'b0, 12'h000), 3, 1'b0, 32'd0, 5'd4, 32'd0, 1};
      vecs[3]  = '{"sub_r0",     mk(OP_SUB, 5'd0, 5'd2, 5'd0, 1'b1, 12'h001), 3, 1'b0, 32'd11, 5'd0, 32'd0, 1};
      vecs[4]  = '{"illegal_0000", mk(4'b0000, 5'd5, 5'd2, 5'd2, 1'b0, 12'h000), 1, 1'b1, 32'd11, 5'd5, 32'd0, 0};
      vecs[5]  = '{"slt_r6",     mk(OP_SLT, 5'd6, 5'd1, 5'd2, 1'b0, 12'h000), 3, 1'b0, 32'd1, 5'd6, 32'd1, 1};
      vecs[6]  = '{"div_r8",     mk(OP_DIV, 5'd8, 5'd2, 5'd0, 1'b1, 12'h005), 3, 1'b0, 32'd2, 5'd8, 32'd2, 1};
      vecs[7]  = '{"mfhi_r9",    mk(OP_MFHI, 5'd9, 5'd0, 5'd0, 1'b0, 12'h000), 3, 1'b0, 32'd2, 5'd9, 32'd2, 1};
      vecs[8]  = '{"imm_zext",   mk(OP_ADD, 5'd10, 5'd0, 5'd0, 1'b1, 12'hFFF), 3, 1'b0, 32'd4095, 5'd10, 32'd4095, 1};
      vecs[9]  = '{"add_rt",     mk(OP_ADD, 5'd11, 5'd1, 5'd2, 1'b0, 12'hABC), 3, 1'b0, 32'd17, 5'd11, 32'd17, 1};
      vecs[10] = '{"sub_neg",    mk(OP_SUB, 5'd12, 5'd1, 5'd2, 1'b0, 12'h000), 3, 1'b0, 32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF9, 1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", instr_ready, 1'b1);
      chk("reset_mode", alu_mode, 4'd0);
      chk("reset_done", done, 1'b0);
      chk("reset_err", err, 1'b0);
      chk("reset_result", result, 32'd0);
      nz = 0;
      for (int a = 1; a < 32; a++) begin
         rd_reg(a[4:0], rv);
         if (rv != {N{1'b0}}) nz++;
      end
      chk("reset_regs_nonzero", nz, 0);

      // Back-to-back: ADD r1 = r0 + 5, then ADD r2 = r1 + 7 held valid
      @(negedge clk);
      d0 = done_cnt; m0 = mode_cnt;
      instr = mk(OP_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 12'd5); instr_valid = 1'b1;
      @(posedge clk);
      #1 instr = mk(OP_ADD, 5'd2, 5'd1, 5'd0, 1'b1, 12'd7);
      gap = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (instr_ready && gap == 0) gap = k;
         if (gap != 0) break;
      end
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("b2b_accept_gap", gap, 3);
      chk("b2b_done_pulses", done_cnt - d0, 2);
      chk("b2b_mode_cycles", mode_cnt - m0, 2);
      chk("b2b_result", result, 32'd12);
      rd_reg(5'd1, rv); chk("b2b_r1", rv, 32'd5);
      rd_reg(5'd2, rv); chk("b2b_r2", rv, 32'd12);

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Reset during WB of ADD r7 = r2 + 1
      @(negedge clk);
      instr = mk(OP_ADD, 5'd7, 5'd2, 5'd0, 1'b1, 12'd1); instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstwb_in_wb_ready", instr_ready, 1'b0);
      d0 = done_cnt;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstwb_ready", instr_ready, 1'b1);
      chk("rstwb_done", done, 1'b0);
      repeat (3) @(negedge clk);
      chk("rstwb_done_pulses", done_cnt - d0, 0);
      chk("rstwb_result", result, 32'd0);
      rd_reg(5'd7, rv); chk("rstwb_r7", rv, 32'd0);
      rd_reg(5'd2, rv); chk("rstwb_r2_cleared", rv, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Multi-cycle issue/writeback sequencer that sits directly upstream of the N-bit clocked ALU. It drives the ALU's x, y and mode inputs and consumes its z output.
- Owns a 32-entry N-bit register file. It accepts one instruction word per valid/ready handshake and reads the rs/rt operands (rt or an immediate).
- It issues exactly one ALU operation, captures z one clock later and writes it back to rd. Completion is signalled with a done pulse.

Parameters:
- N, 32, datapath width; must be >= 12.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- instr_valid  input  1  instruction word present.
- instr_ready  output  1  high when the block can accept an instruction.
- instr  input  32  instruction: [31:28] op (ALU mode code), [27:23] rd, [22:18] rs, [17:13] rt, [12] imm_sel, [11:0] imm.
- alu_x  output  N  ALU operand x.
- alu_y  output  N  ALU operand y.
- alu_mode  output  4  ALU mode; 4'b0000 (no-op) except during the issue cycle.
- alu_z  input  N  ALU result, registered inside the ALU.
- done  output  1  one-cycle pulse: instruction retired.
- err  output  1  one-cycle pulse, coincident with done: illegal op.
- result  output  N  value retired with the last done; holds until the next done.
- dbg_addr  input  5  register-file debug read address.
- dbg_data  output  N  combinational read of regfile[dbg_addr]; reads 0 for address 0.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; all 32 registers, alu_x, alu_y, result cleared to 0; alu_mode=0; done=0; err=0.
  - Reset mid-instruction aborts it: no writeback, no done.
- Register r0 reads 0 always; writes to rd=0 are dropped, but done still pulses.
- States:
  - IDLE: instr_ready=1.
  - ISSUE: instr_ready=0.
  - WB: instr_ready=0.
- Accept edge A: at an edge with instr_valid and instr_ready high, while in IDLE.
  - Legal op: registers alu_x=reg[rs]; alu_y = imm_sel ? zero-extended imm : reg[rt]; alu_mode=op; latches rd; goes to ISSUE.
  - Illegal op (4'b0000 or 4'b1100): no ALU issue, no writeback. At edge A, done=1, err=1, result unchanged. Stays IDLE.
- ISSUE (cycle after A): ALU samples x/y/mode at edge A+1. At A+1, alu_mode returns to 0; go to WB.
  - alu_x and alu_y hold their values until the next issue.
- WB (cycle after A+1): alu_z is valid.
  - At A+2: regfile[rd]<=alu_z (unless rd=0); result<=alu_z; done=1; go to IDLE.
- Timing:
  - Latency: done is high in the cycle after edge A+2.
  - Next accept is possible at A+3, so the maximum rate is one instruction per 3 clocks.
  - The write lands before any later read, so no forwarding is needed.
- done and err are high for exactly one cycle per retired instruction.
- instr_valid while instr_ready=0 is ignored. The instruction is not latched, and the source must hold it.
- The block does not interpret results:
  - MUL/DIV hi side effects and MFHI are entirely the ALU's.
  - Divide by zero is not trapped; whatever alu_z holds is written.
- The ALU never sees a non-zero mode for more than one cycle per instruction. This guarantees MUL/DIV update hi exactly once.
- The register file has no reset-bypass. All writes occur only in the WB->IDLE transition.

Test Plan:
- Reset, then dbg read r1..r31 -> all 0; instr_ready=1, alu_mode=0, done=0.
- ADD r1 = r0 + imm 5, then ADD r2 = r1 + imm 7 (back-to-back valid):
  - the second accept occurs 3 clocks after the first;
  - r1=5, r2=12; done pulses twice, result=12.
- MUL r3 = r2*r2 (12*12), then MFHI r4:
  - r3=144, r4=0;
  - alu_mode is non-zero for exactly one cycle per instruction.
- Illegal op 4'b1100, rd=5:
  - done=err=1 in the cycle after accept; r5 unchanged; no non-zero alu_mode cycle.
- SUB r0 = r2 - imm 1 -> done=1, result=11, dbg r0 reads 0. SLT r6 = r1<r2 -> r6=1.
- Assert rst during WB of ADD r7 = r2 + imm 1:
  - no done pulse; r7=0; state IDLE with instr_ready=1 next cycle.
